// File: rtl/mpu_common.sv
// Shared MPU constants and types for the allocation control table (ACT)
// and for the allocator that claims its entries.
package mpu_common;

    localparam int ADDR_WIDTH       = 16;
    localparam int CORE_ID_WIDTH    = 4;
    localparam int BLOCK_COUNT_BITS = 4;
    localparam int REGION_SHIFT     = 6;
    localparam int BLOCK_COUNT      = 1 << BLOCK_COUNT_BITS;
    localparam int BLOCK_SIZE       = 1 << REGION_SHIFT;

    typedef struct packed {
        logic                        valid;
        logic [CORE_ID_WIDTH-1:0]    owner;
        logic [BLOCK_COUNT_BITS-1:0] reservation_id;
    } entry_t;

    typedef enum logic [2:0] {
        ALLOC_IDLE,
        ALLOC_READ,
        ALLOC_WAIT,
        ALLOC_CHECK,
        ALLOC_WRITE,
        ALLOC_RESULT
    } alloc_state_t;

    typedef enum logic [1:0] {
        ALLOC_NO_ERROR,
        ALLOC_ZERO_SIZE,
        ALLOC_NO_RESERVATION,
        ALLOC_NO_SPACE
    } alloc_error_t;

endpackage

// File: rtl/alloc.sv
// First-fit block allocator: scans the ACT for N consecutive free blocks,
// claims them under a reservation ID and reports the region base address.
module alloc
    import mpu_common::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cs,
    input  logic [ADDR_WIDTH-1:0]       size,
    input  logic [CORE_ID_WIDTH-1:0]    core_id,
    input  logic [BLOCK_COUNT_BITS-1:0] reservation_id_in,
    input  logic                        reservation_valid,
    output logic                        reservation_dequeue,
    input  entry_t                      act_rdata,
    output logic                        act_cs,
    output logic                        act_we,
    output logic [BLOCK_COUNT_BITS-1:0] act_addr,
    output entry_t                      act_wdata,
    output logic [ADDR_WIDTH-1:0]       addr_out,
    output logic                        bsy,
    output logic                        rdy,
    output alloc_error_t                err
);

    alloc_state_t                state, state_n;
    logic [BLOCK_COUNT_BITS-1:0] idx, idx_n, run_start, run_start_n, wptr, wptr_n;
    logic [BLOCK_COUNT_BITS:0]   run_len, run_len_n, wcnt, wcnt_n;
    logic [ADDR_WIDTH:0]         n_reg, n_reg_n, n_calc;
    logic [CORE_ID_WIDTH-1:0]    core_reg, core_reg_n;
    logic [BLOCK_COUNT_BITS-1:0] rid_reg, rid_reg_n;
    logic                        act_cs_n, act_we_n, bsy_n, rdy_n, deq_n;
    logic [BLOCK_COUNT_BITS-1:0] act_addr_n;
    entry_t                      act_wdata_n;
    logic [ADDR_WIDTH-1:0]       addr_out_n;
    alloc_error_t                err_n;
    logic [BLOCK_COUNT_BITS:0]   len_new;
    logic [BLOCK_COUNT_BITS-1:0] start_new;
    logic                        unused_rdata;

    // Only the valid flag decides whether a block is free.
    assign unused_rdata = ^{act_rdata.owner, act_rdata.reservation_id};

    assign n_calc = ({1'b0, size} + (ADDR_WIDTH+1)'(BLOCK_SIZE - 1)) >> REGION_SHIFT;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        run_start_n = run_start;
        run_len_n   = run_len;
        wptr_n      = wptr;
        wcnt_n      = wcnt;
        n_reg_n     = n_reg;
        core_reg_n  = core_reg;
        rid_reg_n   = rid_reg;
        act_cs_n    = act_cs;
        act_we_n    = act_we;
        act_addr_n  = act_addr;
        act_wdata_n = act_wdata;
        addr_out_n  = addr_out;
        bsy_n       = bsy;
        rdy_n       = rdy;
        deq_n       = reservation_dequeue;
        err_n       = err;
        len_new     = '0;
        start_new   = run_start;

        case (state)
            ALLOC_IDLE: if (cs) begin
                core_reg_n = core_id;
                rid_reg_n  = reservation_id_in;
                n_reg_n    = n_calc;
                bsy_n      = 1'b1;
                err_n      = ALLOC_NO_ERROR;
                // Early errors park in RESULT one cycle before raising rdy.
                if (size == '0) begin
                    err_n   = ALLOC_ZERO_SIZE;
                    state_n = ALLOC_RESULT;
                end else if (!reservation_valid) begin
                    err_n   = ALLOC_NO_RESERVATION;
                    state_n = ALLOC_RESULT;
                end else if (n_calc > (ADDR_WIDTH+1)'(BLOCK_COUNT)) begin
                    err_n   = ALLOC_NO_SPACE;
                    state_n = ALLOC_RESULT;
                end else begin
                    idx_n       = '0;
                    run_start_n = '0;
                    run_len_n   = '0;
                    act_cs_n    = 1'b1;
                    act_we_n    = 1'b0;
                    act_addr_n  = '0;
                    state_n     = ALLOC_READ;
                end
            end
            ALLOC_READ: begin
                act_cs_n = 1'b0;
                state_n  = ALLOC_WAIT;
            end
            ALLOC_WAIT: state_n = ALLOC_CHECK;
            ALLOC_CHECK: begin
                if (!act_rdata.valid) begin
                    len_new   = run_len + 1'b1;
                    start_new = (run_len == '0) ? idx : run_start;
                end
                run_len_n   = len_new;
                run_start_n = start_new;
                if ((ADDR_WIDTH+1)'(len_new) == n_reg) begin
                    wptr_n  = start_new;
                    wcnt_n  = '0;
                    state_n = ALLOC_WRITE;
                end else if (idx == BLOCK_COUNT_BITS'(BLOCK_COUNT - 1)) begin
                    err_n   = ALLOC_NO_SPACE;
                    rdy_n   = 1'b1;
                    state_n = ALLOC_RESULT;
                end else begin
                    idx_n      = idx + 1'b1;
                    act_cs_n   = 1'b1;
                    act_we_n   = 1'b0;
                    act_addr_n = idx + 1'b1;
                    state_n    = ALLOC_READ;
                end
            end
            ALLOC_WRITE: begin
                if ((ADDR_WIDTH+1)'(wcnt) != n_reg) begin
                    act_cs_n    = 1'b1;
                    act_we_n    = 1'b1;
                    act_addr_n  = wptr;
                    act_wdata_n = '{valid: 1'b1, owner: core_reg, reservation_id: rid_reg};
                    wptr_n      = wptr + 1'b1;
                    wcnt_n      = wcnt + 1'b1;
                end else begin
                    act_cs_n   = 1'b0;
                    act_we_n   = 1'b0;
                    addr_out_n = ADDR_WIDTH'(run_start) << REGION_SHIFT;
                    deq_n      = 1'b1;
                    rdy_n      = 1'b1;
                    state_n    = ALLOC_RESULT;
                end
            end
            ALLOC_RESULT: begin
                if (!rdy) begin
                    rdy_n = 1'b1;
                end else begin
                    rdy_n   = 1'b0;
                    deq_n   = 1'b0;
                    bsy_n   = 1'b0;
                    state_n = ALLOC_IDLE;
                end
            end
            default: state_n = ALLOC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ALLOC_IDLE;
            idx                 <= '0;
            run_start           <= '0;
            run_len             <= '0;
            wptr                <= '0;
            wcnt                <= '0;
            n_reg               <= '0;
            core_reg            <= '0;
            rid_reg             <= '0;
            act_cs              <= 1'b0;
            act_we              <= 1'b0;
            act_addr            <= '0;
            act_wdata           <= '0;
            addr_out            <= '0;
            bsy                 <= 1'b0;
            rdy                 <= 1'b0;
            reservation_dequeue <= 1'b0;
            err                 <= ALLOC_NO_ERROR;
        end else begin
            state               <= state_n;
            idx                 <= idx_n;
            run_start           <= run_start_n;
            run_len             <= run_len_n;
            wptr                <= wptr_n;
            wcnt                <= wcnt_n;
            n_reg               <= n_reg_n;
            core_reg            <= core_reg_n;
            rid_reg             <= rid_reg_n;
            act_cs              <= act_cs_n;
            act_we              <= act_we_n;
            act_addr            <= act_addr_n;
            act_wdata           <= act_wdata_n;
            addr_out            <= addr_out_n;
            bsy                 <= bsy_n;
            rdy                 <= rdy_n;
            reservation_dequeue <= deq_n;
            err                 <= err_n;
        end
    end

endmodule

// File: tb/tb_alloc.sv
// Directed bench for alloc: behavioural ACT memory, expected results queued
// per request and checked when rdy pulses.
module tb_alloc;
    import mpu_common::*;

    logic                        clk, rst, cs, reservation_valid, reservation_dequeue;
    logic [ADDR_WIDTH-1:0]       size, addr_out;
    logic [CORE_ID_WIDTH-1:0]    core_id;
    logic [BLOCK_COUNT_BITS-1:0] reservation_id_in, act_addr;
    logic                        act_cs, act_we, bsy, rdy;
    entry_t                      act_rdata, act_wdata;
    alloc_error_t                err;

    alloc dut (
        .clk(clk), .rst(rst), .cs(cs), .size(size), .core_id(core_id),
        .reservation_id_in(reservation_id_in), .reservation_valid(reservation_valid),
        .reservation_dequeue(reservation_dequeue), .act_rdata(act_rdata),
        .act_cs(act_cs), .act_we(act_we), .act_addr(act_addr), .act_wdata(act_wdata),
        .addr_out(addr_out), .bsy(bsy), .rdy(rdy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t mem [BLOCK_COUNT];
    int wr_cnt = 0, acs_cnt = 0, dq_cnt = 0;

    always @(posedge clk) begin
        if (act_cs) begin
            acs_cnt <= acs_cnt + 1;
            if (act_we) begin
                mem[act_addr] <= act_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                act_rdata <= mem[act_addr];
            end
        end
        if (reservation_dequeue) dq_cnt <= dq_cnt + 1;
    end

    typedef struct {
        alloc_error_t          err;
        logic [ADDR_WIDTH-1:0] addr;
        int                    lat;
        int                    writes;
        int                    reads_writes;
    } exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_occupied(input int lo, input int hi);
        for (int i = 0; i < BLOCK_COUNT; i++)
            mem[i] = (i >= lo && i <= hi) ? entry_t'{1'b1, 4'd1, 4'd1} : entry_t'('0);
    endtask

    // Issue one request, measure edges to rdy, compare against the queue head.
    task automatic run_req(input string tag, input logic [ADDR_WIDTH-1:0] sz,
                           input logic [3:0] cid, input logic [3:0] rid,
                           input logic rv, input int glitch);
        exp_t e;
        int w0, a0, d0, lat;
        w0 = wr_cnt; a0 = acs_cnt; d0 = dq_cnt;
        size = sz; core_id = cid; reservation_id_in = rid; reservation_valid = rv;
        cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        chk({tag, "_bsy_edge0"}, bsy, 1);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == glitch) begin cs = 1'b1; size = '0; end
            else cs = 1'b0;
            @(posedge clk); #1;
            if (rdy) begin lat = i; break; end
        end
        cs = 1'b0;
        e = sb.pop_front();
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_err"}, err, e.err);
        chk({tag, "_addr"}, addr_out, e.addr);
        chk({tag, "_writes"}, wr_cnt - w0, e.writes);
        chk({tag, "_act_cs_count"}, acs_cnt - a0, e.reads_writes);
        chk({tag, "_deq_with_rdy"}, reservation_dequeue, e.err == ALLOC_NO_ERROR);
        @(posedge clk); #1;
        chk({tag, "_rdy_width"}, rdy, 0);
        chk({tag, "_bsy_done"}, bsy, 0);
        chk({tag, "_deq_count"}, dq_cnt - d0, (e.err == ALLOC_NO_ERROR) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; size = '0; core_id = '0;
        reservation_id_in = '0; reservation_valid = 1'b0;
        set_occupied(1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bsy", bsy, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_err", err, ALLOC_NO_ERROR);
        chk("reset_addr", addr_out, 0);
        chk("reset_act_cs", act_cs, 0);
        chk("reset_deq", reservation_dequeue, 0);
        rst = 1'b0;

        // Basic: N=2 from an empty table, two blocks examined.
        sb.push_back('{ALLOC_NO_ERROR, 16'h000, 9, 2, 4});
        run_req("basic", 16'd100, 4'd2, 4'd5, 1'b1, 0);
        chk("basic_blk0", mem[0], entry_t'{1'b1, 4'd2, 4'd5});
        chk("basic_blk1", mem[1], entry_t'{1'b1, 4'd2, 4'd5});
        chk("basic_blk2_free", mem[2].valid, 0);

        // First fit skips the single-block gap at 3.
        set_occupied(0, 2);
        mem[4] = entry_t'{1'b1, 4'd1, 4'd1};
        sb.push_back('{ALLOC_NO_ERROR, 16'h140, 24, 2, 9});
        run_req("gap", 16'd128, 4'd3, 4'd7, 1'b1, 0);
        chk("gap_blk5", mem[5], entry_t'{1'b1, 4'd3, 4'd7});
        chk("gap_blk6", mem[6], entry_t'{1'b1, 4'd3, 4'd7});
        chk("gap_blk3_free", mem[3].valid, 0);

        sb.push_back('{ALLOC_ZERO_SIZE, 16'h140, 1, 0, 0});
        run_req("zero", 16'd0, 4'd1, 4'd2, 1'b1, 0);

        sb.push_back('{ALLOC_NO_RESERVATION, 16'h140, 1, 0, 0});
        run_req("nores", 16'd64, 4'd1, 4'd2, 1'b0, 0);

        // Only 14..15 free: runs cannot extend past the last block.
        set_occupied(0, 13);
        sb.push_back('{ALLOC_NO_SPACE, 16'h140, 48, 0, 16});
        run_req("end_192", 16'd192, 4'd4, 4'd3, 1'b1, 0);
        sb.push_back('{ALLOC_NO_ERROR, 16'h380, 51, 2, 18});
        run_req("end_128", 16'd128, 4'd4, 4'd3, 1'b1, 0);
        chk("end_blk15", mem[15], entry_t'{1'b1, 4'd4, 4'd3});
        sb.push_back('{ALLOC_NO_SPACE, 16'h380, 1, 0, 0});
        run_req("end_2048", 16'd2048, 4'd4, 4'd3, 1'b1, 0);

        // Reset in the middle of a scan.
        set_occupied(1, 0);
        size = 16'd64; core_id = 4'd6; reservation_id_in = 4'd8; reservation_valid = 1'b1;
        cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midscan_bsy", bsy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_bsy", bsy, 0);
        chk("abort_addr", addr_out, 0);
        chk("abort_act_cs", act_cs, 0);
        chk("abort_err", err, ALLOC_NO_ERROR);
        chk("abort_no_write", mem[0].valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // cs pulsed while busy with size 0 must not disturb the result.
        mem[0] = entry_t'{1'b1, 4'd1, 4'd1};
        sb.push_back('{ALLOC_NO_ERROR, 16'h040, 8, 1, 3});
        run_req("busy", 16'd64, 4'd9, 4'd12, 1'b1, 3);
        chk("busy_blk1", mem[1], entry_t'{1'b1, 4'd9, 4'd12});
        chk("busy_blk2_free", mem[2].valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
